reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Final pipeline stage; the write-side counterpart of the ALU operand-select stage, which reads rd/rs from the register file.
- Takes the ALU result plus its enable pulse and retires the instruction:
  - ALU ops: writes the result to register rd.
  - LDR: fetches memory data and writes it to rd.
  - STR: writes store data to memory.
  - Compare/branch: retires with no write.
- Runs the data-memory req/ready handshake with a timeout, then pulses en_out to the PC/fetch stage.

Parameters:
- DATA_W, 16, datapath and memory-address width
- REG_AW, 3, register-file address width (8 registers)
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready before aborting (1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- en_in  in  1  one-cycle pulse: ALU result valid
- wb_sel  in  2  00 ALU write, 01 load, 10 store, 11 no write
- alu_result  in  DATA_W  ALU output; also the memory address for load/store
- rd_addr_in  in  REG_AW  destination register
- store_data  in  DATA_W  value to store (rd contents)
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready=1
- mem_ready  in  1  memory completes the current request
- err_clr  in  1  clears sticky error flags
- mem_req  out  1  memory request, level, held until ready or timeout
- mem_we  out  1  1=write, 0=read; valid while mem_req=1
- mem_addr  out  DATA_W  request address
- mem_wdata  out  DATA_W  write data
- reg_we  out  1  one-cycle register-file write strobe
- reg_waddr  out  REG_AW  write address
- reg_wdata  out  DATA_W  write data
- en_out  out  1  one-cycle pulse: instruction retired
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  sticky: memory timeout occurred
- err_overrun  out  1  sticky: en_in arrived while busy

Behaviour:
- Reset (rst=0, async): state=IDLE; every output 0; timeout counter 0.
- All outputs are registered.
- States:
  - IDLE: accept en_in.
  - MEM: request outstanding.
  - Return to IDLE after retire.
- IDLE, en_in=1 sampled at edge N, by wb_sel:
  - 00: for the cycle after N, reg_we=1, reg_waddr=rd_addr_in, reg_wdata=alu_result, en_out=1. Stay IDLE.
  - 11: for the cycle after N, en_out=1 only. Stay IDLE.
  - 01: after N, mem_req=1, mem_we=0, mem_addr=alu_result. Latch rd_addr_in. Go to MEM.
  - 10: after N, mem_req=1, mem_we=1, mem_addr=alu_result, mem_wdata=store_data. Go to MEM.
- MEM:
  - mem_addr, mem_we and mem_wdata are stable while mem_req=1.
  - Counter increments each cycle.
  - mem_ready=1 sampled at edge M: mem_req=0 after M. Return to IDLE.
    - Load: after M, reg_we=1, reg_wdata=mem_rdata (sampled at M), en_out=1.
    - Store: after M, en_out=1 only.
  - Best case: mem_ready already high in the first MEM cycle gives 2-cycle load/store latency (en_in edge to en_out).
  - Timeout: counter reaches MEM_TIMEOUT with no ready (ready on the same edge wins). Then mem_req=0, err_timeout=1, en_out=1, no reg_we. Return to IDLE so the CPU never hangs.
- en_in=1 while busy: ignored (no capture, no effect on the current operation), err_overrun=1.
- en_in=1 in IDLE on the cycle after a retire is accepted normally, so back-to-back ALU ops retire every cycle.
- mem_ready=1 in IDLE: ignored.
- err_clr=1: clears both sticky flags on the next edge. A set event on the same edge wins.
- reg_we and en_out are never high for more than one consecutive cycle per instruction.
- Reset mid-MEM: immediate abort, all outputs 0, no write.

Decomposition:
- Shared package cpu_pkg holds:
  - WB_ALU/WB_LOAD/WB_STORE/WB_NONE wb_sel encodings
  - WB_IDLE/WB_MEM state encodings
  - DATA_W/REG_AW constants, which the ALU-operand stage also uses
- One natural sub-module, wb_timeout_cnt: 8-bit counter with clear/enable and expired flag at MEM_TIMEOUT.

Test Plan:
- ALU write: en_in pulse, wb_sel=00, rd=3, alu_result=0x1234 -> next cycle reg_we=1, reg_waddr=3, reg_wdata=0x1234, en_out=1. Both low the cycle after.
- Load, 3 wait cycles: wb_sel=01, rd=5, alu_result=0x0040, mem_ready after 3 cycles with mem_rdata=0xBEEF -> mem_req high 4 cycles, addr 0x0040, we=0; then reg_we=1, reg_waddr=5, reg_wdata=0xBEEF, en_out=1.
- Store, immediate ready: wb_sel=10, alu_result=0x0010, store_data=0xA5A5, mem_ready tied 1 -> one mem_req cycle, we=1, wdata=0xA5A5; en_out next cycle; reg_we never 1.
- Timeout: load with mem_ready held 0, MEM_TIMEOUT=15 -> mem_req drops after 15 MEM cycles, err_timeout=1, en_out=1, reg_we=0. err_clr pulse -> err_timeout=0.
- Overrun and reset: second en_in during a store wait -> err_overrun=1 and the store still completes unchanged. Separately, rst=0 mid-load -> all outputs 0 immediately and no reg_we after release.
- Back-to-back: three consecutive en_in cycles with wb_sel=00 and rd=1,2,3 -> three consecutive reg_we cycles in order, busy stays 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath widths, writeback select codes and
// writeback FSM states, used by the operand-select and writeback stages.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int REG_AW = 3;

   typedef enum logic [1:0] {
      WB_ALU   = 2'b00,
      WB_LOAD  = 2'b01,
      WB_STORE = 2'b10,
      WB_NONE  = 2'b11
   } wb_sel_t;

   typedef enum logic {
      WB_IDLE = 1'b0,
      WB_MEM  = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_timeout_cnt.sv
// Memory-wait counter for the writeback stage: counts MEM cycles and flags
// the cycle that is the LIMIT-th wait without a ready.
module wb_timeout_cnt #(
   parameter int LIMIT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [7:0] count;

   // NOTE: clocked state is assigned with <= so every register samples the
   // pre-edge values; blocking = here would create order-dependent races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 8'd1;
      end
   end

   // count holds the number of already-finished wait cycles
   assign expired = en && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage: retires ALU results to the register file, runs load/store
// through the data-memory req/ready handshake with timeout, pulses en_out.
module reg_writeback #(
   parameter int DATA_W      = cpu_pkg::DATA_W,
   parameter int REG_AW      = cpu_pkg::REG_AW,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_in,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [REG_AW-1:0] rd_addr_in,
   input  logic [DATA_W-1:0] store_data,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   input  logic              err_clr,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              reg_we,
   output logic [REG_AW-1:0] reg_waddr,
   output logic [DATA_W-1:0] reg_wdata,
   output logic              en_out,
   output logic              busy,
   output logic              err_timeout,
   output logic              err_overrun
);

   import cpu_pkg::*;

   wb_state_t         state_q, state_d;
   logic [REG_AW-1:0] rd_q, rd_d;
   logic              mem_req_d, mem_we_d, reg_we_d, en_out_d;
   logic [DATA_W-1:0] mem_addr_d, mem_wdata_d, reg_wdata_d;
   logic [REG_AW-1:0] reg_waddr_d;
   logic              err_timeout_d, err_overrun_d;
   logic              expired;

   wb_timeout_cnt #(.LIMIT(MEM_TIMEOUT)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q == WB_IDLE),
      .en      (state_q == WB_MEM),
      .expired (expired)
   );

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d       = state_q;
      rd_d          = rd_q;
      mem_req_d     = mem_req;
      mem_we_d      = mem_we;
      mem_addr_d    = mem_addr;
      mem_wdata_d   = mem_wdata;
      reg_we_d      = 1'b0;
      reg_waddr_d   = reg_waddr;
      reg_wdata_d   = reg_wdata;
      en_out_d      = 1'b0;
      err_timeout_d = err_clr ? 1'b0 : err_timeout;
      err_overrun_d = err_clr ? 1'b0 : err_overrun;

      case (state_q)
         WB_IDLE: begin
            if (en_in) begin
               case (wb_sel_t'(wb_sel))
                  WB_ALU: begin
                     reg_we_d    = 1'b1;
                     reg_waddr_d = rd_addr_in;
                     reg_wdata_d = alu_result;
                     en_out_d    = 1'b1;
                  end
                  WB_NONE: en_out_d = 1'b1;
                  WB_LOAD, WB_STORE: begin
                     state_d    = WB_MEM;
                     rd_d       = rd_addr_in;
                     mem_req_d  = 1'b1;
                     mem_we_d   = (wb_sel_t'(wb_sel) == WB_STORE);
                     mem_addr_d = alu_result;
                     if (wb_sel_t'(wb_sel) == WB_STORE) mem_wdata_d = store_data;
                  end
               endcase
            end
         end
         WB_MEM: begin
            if (en_in) err_overrun_d = 1'b1;
            // ready on the final wait cycle still completes normally
            if (mem_ready) begin
               state_d   = WB_IDLE;
               mem_req_d = 1'b0;
               en_out_d  = 1'b1;
               if (!mem_we) begin
                  reg_we_d    = 1'b1;
                  reg_waddr_d = rd_q;
                  reg_wdata_d = mem_rdata;
               end
            end else if (expired) begin
               state_d       = WB_IDLE;
               mem_req_d     = 1'b0;
               en_out_d      = 1'b1;
               err_timeout_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= WB_IDLE;
         rd_q        <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         reg_we      <= 1'b0;
         reg_waddr   <= '0;
         reg_wdata   <= '0;
         en_out      <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         state_q     <= state_d;
         rd_q        <= rd_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         reg_we      <= reg_we_d;
         reg_waddr   <= reg_waddr_d;
         reg_wdata   <= reg_wdata_d;
         en_out      <= en_out_d;
         busy        <= (state_d == WB_MEM);
         err_timeout <= err_timeout_d;
         err_overrun <= err_overrun_d;
      end
   end

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: directed scenarios plus random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_reg_writeback;

   localparam int DATA_W      = 16;
   localparam int REG_AW      = 3;
   localparam int MEM_TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              en_in = 1'b0;
   logic [1:0]        wb_sel = 2'b00;
   logic [DATA_W-1:0] alu_result = '0;
   logic [REG_AW-1:0] rd_addr_in = '0;
   logic [DATA_W-1:0] store_data = '0;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic              mem_ready = 1'b0;
   logic              err_clr = 1'b0;
   logic              mem_req, mem_we, reg_we, en_out, busy, err_timeout, err_overrun;
   logic [DATA_W-1:0] mem_addr, mem_wdata, reg_wdata;
   logic [REG_AW-1:0] reg_waddr;

   int checks = 0;
   int errors = 0;
   int req_cycles = 0;

   reg_writeback #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst(rst), .en_in(en_in), .wb_sel(wb_sel), .alu_result(alu_result),
      .rd_addr_in(rd_addr_in), .store_data(store_data), .mem_rdata(mem_rdata),
      .mem_ready(mem_ready), .err_clr(err_clr), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .reg_we(reg_we), .reg_waddr(reg_waddr),
      .reg_wdata(reg_wdata), .en_out(en_out), .busy(busy), .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: one outstanding memory transaction, tracked by how many
   // cycles it has already waited.
   bit        m_pending, m_is_store;
   int        m_waited;
   bit [2:0]  m_rd;
   bit [15:0] m_addr, m_wdata;
   bit        e_req, e_reg_we, e_en_out, e_t, e_o;
   bit [2:0]  e_waddr;
   bit [15:0] e_wdata;

   task automatic model_reset();
      m_pending = 0; m_waited = 0;
      e_req = 0; e_reg_we = 0; e_en_out = 0; e_t = 0; e_o = 0;
   endtask

   task automatic model_step();
      bit t_set = 0, o_set = 0;
      e_reg_we = 0;
      e_en_out = 0;
      if (!m_pending) begin
         if (en_in) begin
            if (wb_sel == 2'b00) begin
               e_reg_we = 1; e_waddr = rd_addr_in; e_wdata = alu_result; e_en_out = 1;
            end else if (wb_sel == 2'b11) begin
               e_en_out = 1;
            end else begin
               m_pending = 1; m_waited = 0; m_is_store = (wb_sel == 2'b10);
               m_rd = rd_addr_in; m_addr = alu_result; m_wdata = store_data;
               e_req = 1;
            end
         end
      end else begin
         if (en_in) o_set = 1;
         m_waited++;
         if (mem_ready) begin
            m_pending = 0; e_req = 0; e_en_out = 1;
            if (!m_is_store) begin
               e_reg_we = 1; e_waddr = m_rd; e_wdata = mem_rdata;
            end
         end else if (m_waited == MEM_TIMEOUT) begin
            m_pending = 0; e_req = 0; e_en_out = 1; t_set = 1;
         end
      end
      e_t = t_set ? 1'b1 : (err_clr ? 1'b0 : e_t);
      e_o = o_set ? 1'b1 : (err_clr ? 1'b0 : e_o);
   endtask

   task automatic compare_outputs();
      check("mem_req", mem_req, e_req);
      check("busy", busy, m_pending);
      check("en_out", en_out, e_en_out);
      check("reg_we", reg_we, e_reg_we);
      check("err_timeout", err_timeout, e_t);
      check("err_overrun", err_overrun, e_o);
      if (e_req) begin
         check("mem_we", mem_we, m_is_store);
         check("mem_addr", mem_addr, m_addr);
         if (m_is_store) check("mem_wdata", mem_wdata, m_wdata);
      end
      if (e_reg_we) begin
         check("reg_waddr", reg_waddr, e_waddr);
         check("reg_wdata", reg_wdata, e_wdata);
      end
      if (mem_req) req_cycles++;
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic issue(input logic [1:0] sel, input logic [2:0] rd,
                        input logic [15:0] alu, input logic [15:0] sd);
      en_in = 1; wb_sel = sel; rd_addr_in = rd; alu_result = alu; store_data = sd;
      step();
      en_in = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_outs"}, {mem_req, mem_we, mem_addr, mem_wdata, reg_we},
            {1'b0, 1'b0, 16'h0, 16'h0, 1'b0});
      check({tag, "_outs2"}, {reg_waddr, reg_wdata, en_out, busy, err_timeout, err_overrun},
            {3'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0});
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1;

      // ALU write, then idle cycle
      issue(2'b00, 3'd3, 16'h1234, 16'h0);
      check("alu_wdata", reg_wdata, 16'h1234);
      step();
      check("alu_we_drop", {reg_we, en_out}, 2'b00);

      // load with three wait cycles
      req_cycles = 0;
      issue(2'b01, 3'd5, 16'h0040, 16'h0);
      repeat (3) step();
      mem_ready = 1; mem_rdata = 16'hBEEF;
      step();
      mem_ready = 0;
      check("load_req_cycles", req_cycles, 4);
      check("load_result", {reg_we, reg_waddr, reg_wdata, en_out}, {1'b1, 3'd5, 16'hBEEF, 1'b1});
      step();

      // store with ready already high
      mem_ready = 1; req_cycles = 0;
      issue(2'b10, 3'd0, 16'h0010, 16'hA5A5);
      step();
      check("store_req_cycles", req_cycles, 1);
      check("store_retire", {en_out, reg_we}, 2'b10);
      mem_ready = 0;
      step();

      // timeout on a load, then clear
      req_cycles = 0;
      issue(2'b01, 3'd2, 16'h0100, 16'h0);
      repeat (MEM_TIMEOUT) step();
      check("timeout_req_cycles", req_cycles, MEM_TIMEOUT);
      check("timeout_flags", {err_timeout, en_out, reg_we}, 3'b110);
      err_clr = 1; step(); err_clr = 0;
      check("timeout_cleared", err_timeout, 1'b0);

      // overrun during a store wait
      issue(2'b10, 3'd1, 16'h0222, 16'h5A5A);
      step();
      issue(2'b00, 3'd7, 16'hFFFF, 16'h1111);
      check("overrun_set", err_overrun, 1'b1);
      check("overrun_addr", mem_addr, 16'h0222);
      mem_ready = 1; step(); mem_ready = 0;
      check("overrun_store_done", {en_out, reg_we, mem_req}, 3'b100);
      err_clr = 1; step(); err_clr = 0;

      // reset in the middle of a load
      issue(2'b01, 3'd4, 16'h0300, 16'h0);
      step();
      #2 rst = 0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(posedge clk); #1;
      rst = 1;
      mem_ready = 1; mem_rdata = 16'hDEAD;
      repeat (3) step();
      mem_ready = 0;

      // back-to-back ALU ops
      issue(2'b00, 3'd1, 16'h0001, 16'h0);
      check("b2b_1", {reg_we, reg_waddr, busy}, {1'b1, 3'd1, 1'b0});
      issue(2'b00, 3'd2, 16'h0002, 16'h0);
      check("b2b_2", {reg_we, reg_waddr, busy}, {1'b1, 3'd2, 1'b0});
      issue(2'b00, 3'd3, 16'h0003, 16'h0);
      check("b2b_3", {reg_we, reg_waddr, busy}, {1'b1, 3'd3, 1'b0});
      step();

      // random traffic: frequent ready, then rare ready to hit timeouts
      for (int i = 0; i < 3000; i++) begin
         en_in      = ($urandom_range(0, 2) == 0);
         wb_sel     = 2'($urandom_range(0, 3));
         rd_addr_in = 3'($urandom);
         alu_result = 16'($urandom);
         store_data = 16'($urandom);
         mem_rdata  = 16'($urandom);
         mem_ready  = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
         err_clr    = ($urandom_range(0, 15) == 0);
         step();
      end
      en_in = 0; mem_ready = 0; err_clr = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
